// File: rtl/mcp_buf_pkg.sv
// mcp_buf_pkg: shared constants and width helpers for the buffered MCP mux.
// Provides default parameters, a clog2-style helper, channel-tag width and slice index.
package mcp_buf_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DEPTH  = 4;

    // Bits needed to index v items (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Channel tag width, never narrower than one bit.
    function automatic int cw_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Low bit of channel ch inside a packed multi-channel bus.
    function automatic int slice_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/mcp_buf_fifo.sv
// mcp_buf_fifo: single-channel DEPTH x DWIDTH synchronous FIFO, sync active-high reset.
// Ports: clk, rst, push, pop, wdata, rdata (head word, combinational), full, empty.
module mcp_buf_fifo
    import mcp_buf_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers are log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mcp_mux_buf.sv
// mcp_mux_buf: NUM_CH buffered asend/aready producers merged round-robin onto one
// bvalid/bload port with tag bchan. Ports: clk_a, rst_a (sync, active-high), asend,
// adatain, aready, bload, bvalid, bdata, bchan, aerr. Macro MCP_BUF_ERR_EN enables aerr.
module mcp_mux_buf
    import mcp_buf_pkg::*;
#(
    parameter  int DWIDTH = DEF_DWIDTH,
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CW     = cw_of(NUM_CH)
) (
    input  logic                     clk_a,
    input  logic                     rst_a,
    input  logic [NUM_CH-1:0]        asend,
    input  logic [NUM_CH*DWIDTH-1:0] adatain,
    output logic [NUM_CH-1:0]        aready,
    input  logic                     bload,
    output logic                     bvalid,
    output logic [DWIDTH-1:0]        bdata,
    output logic [CW-1:0]            bchan,
    output logic [NUM_CH-1:0]        aerr
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [DWIDTH-1:0] rdata [NUM_CH];

    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     rr_next;
    logic [CW-1:0]     grant;
    logic [DWIDTH-1:0] grant_data;
    logic              found;
    logic              stage_free;

    // A full FIFO refuses the push even if it is popped in the same cycle.
    assign aready     = ~full;
    assign push       = asend & ~full;
    assign stage_free = !bvalid || bload;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mcp_buf_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk    (clk_a),
            .rst    (rst_a),
            .push   (push[g]),
            .pop    (pop[g]),
            .wdata  (adatain[slice_lo(g, DWIDTH) +: DWIDTH]),
            .rdata  (rdata[g]),
            .full   (full[g]),
            .empty  (empty[g])
        );
    end

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        grant      = '0;
        grant_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && !empty[idx]) begin
                found      = 1'b1;
                grant      = CW'(idx);
                grant_data = rdata[idx];
            end
        end
    end

    assign rr_next = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;

    always_comb begin
        pop = '0;
        if (stage_free && found) pop[grant] = 1'b1;
    end

    // Output stage: reloads whenever it is free; otherwise holds.
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            bvalid <= 1'b0;
            bdata  <= '0;
            bchan  <= '0;
            rr_ptr <= '0;
        end else if (stage_free) begin
            if (found) begin
                bvalid <= 1'b1;
                bdata  <= grant_data;
                bchan  <= grant;
                rr_ptr <= rr_next;
            end else begin
                bvalid <= 1'b0;
            end
        end
    end

`ifdef MCP_BUF_ERR_EN
    // Sticky: a send into a full channel is lost and flagged until reset.
    always_ff @(posedge clk_a) begin
        if (rst_a) aerr <= '0;
        else       aerr <= aerr | (asend & full);
    end
`else
    assign aerr = '0;
`endif

endmodule

// File: tb/tb_mcp_mux_buf.sv
// tb_mcp_mux_buf: directed-vector bench for mcp_mux_buf with a queue-based reference
// model checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_mcp_mux_buf;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int DP = 4;

    logic          clk_a;
    logic          rst_a;
    logic [NC-1:0] asend;
    logic [NC*DW-1:0] adatain;
    logic [NC-1:0] aready;
    logic          bload;
    logic          bvalid;
    logic [DW-1:0] bdata;
    logic [1:0]    bchan;
    logic [NC-1:0] aerr;

    mcp_mux_buf #(
        .DWIDTH (DW),
        .NUM_CH (NC),
        .DEPTH  (DP)
    ) dut (
        .clk_a   (clk_a),
        .rst_a   (rst_a),
        .asend   (asend),
        .adatain (adatain),
        .aready  (aready),
        .bload   (bload),
        .bvalid  (bvalid),
        .bdata   (bdata),
        .bchan   (bchan),
        .aerr    (aerr)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one queue per channel plus the presented word.
    logic [DW-1:0] mq [NC][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_chan;
    int            m_rr;
    logic [NC-1:0] m_err;

    logic [DW-1:0] got_d [$];
    int            got_c [$];

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic model_edge();
        bit full_pre [NC];
        bit found;
        int c;
        if (rst_a) begin
            for (int i = 0; i < NC; i++) mq[i].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_rr    = 0;
            m_err   = '0;
        end else begin
            for (int i = 0; i < NC; i++) full_pre[i] = (mq[i].size() == DP);
            if (!m_valid || bload) begin
                found = 0;
                for (int k = 0; k < NC; k++) begin
                    c = (m_rr + k) % NC;
                    if (!found && mq[c].size() > 0) begin
                        found  = 1;
                        m_data = mq[c].pop_front();
                        m_chan = c;
                        m_rr   = (c + 1) % NC;
                    end
                end
                m_valid = found;
            end
            for (int i = 0; i < NC; i++) begin
                if (asend[i]) begin
                    if (!full_pre[i]) mq[i].push_back(adatain[i*DW +: DW]);
`ifdef MCP_BUF_ERR_EN
                    else m_err[i] = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic compare();
        logic [NC-1:0] exp_rdy;
        for (int i = 0; i < NC; i++) exp_rdy[i] = (mq[i].size() != DP);
        chk("bvalid", int'(bvalid), int'(m_valid));
        chk("bdata", int'(bdata), int'(m_data));
        chk("bchan", int'(bchan), m_chan);
        chk("aready", int'(aready), int'(exp_rdy));
        chk("aerr", int'(aerr), int'(m_err));
    endtask

    task automatic step();
        @(posedge clk_a);
        model_edge();
        #1;
        compare();
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] d);
        adatain[ch*DW +: DW] = d;
    endtask

    task automatic record();
        if (bvalid) begin
            got_d.push_back(bdata);
            got_c.push_back(int'(bchan));
        end
    endtask

    initial begin
        logic [DW-1:0] rr_d [8];
        int            rr_c [8];
        int            exp_err;
`ifdef MCP_BUF_ERR_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        rst_a = 1'b1; asend = '0; adatain = '0; bload = 1'b0;
        step(); step();
        rst_a = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) step();
        chk("idle_bvalid", int'(bvalid), 0);
        chk("idle_aready", int'(aready), 'hF);
        chk("idle_bdata", int'(bdata), 0);
        chk("idle_aerr", int'(aerr), 0);

        // Single word: two-edge latency, then empties.
        asend = 4'b0100; set_ch(2, 8'h5A); bload = 1'b1;
        step();
        asend = '0;
        chk("single_n", int'(bvalid), 0);
        step();
        chk("single_v", int'(bvalid), 1);
        chk("single_d", int'(bdata), 'h5A);
        chk("single_c", int'(bchan), 2);
        step();
        chk("single_end", int'(bvalid), 0);

        // Occupy the stage with ch1 so ch0 can fill to DEPTH.
        bload = 1'b0; asend = 4'b0010; set_ch(1, 8'hEE);
        step();
        asend = '0;
        step();
        for (int k = 1; k <= 5; k++) begin
            asend = 4'b0001; set_ch(0, DW'(k));
            step();
            if (k == 4) chk("fill_rdy0", int'(aready[0]), 0);
        end
        asend = '0;
        chk("ovf_aerr0", int'(aerr[0]), exp_err);
        got_d.delete(); got_c.delete();
        bload = 1'b1;
        record();
        for (int i = 0; i < 8; i++) begin step(); record(); end
        chk("drain_n", got_d.size(), 5);
        if (got_d.size() == 5) begin
            chk("drain_d0", int'(got_d[0]), 'hEE);
            chk("drain_c0", got_c[0], 1);
            for (int i = 1; i < 5; i++) begin
                chk("drain_d", int'(got_d[i]), i);
                chk("drain_c", got_c[i], 0);
            end
        end

        // Round-robin from a fresh reset (rr_ptr = 0).
        bload = 1'b0; rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("rst_aerr", int'(aerr), 0);
        for (int k = 1; k <= 2; k++) begin
            asend = 4'hF;
            for (int i = 0; i < NC; i++) set_ch(i, DW'(16*i + k));
            step();
        end
        asend = '0;
        got_d.delete(); got_c.delete();
        bload = 1'b1;
        record();
        for (int i = 0; i < 8; i++) begin step(); record(); end
        rr_d = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h02, 8'h12, 8'h22, 8'h32};
        rr_c = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk("rr_n", got_c.size(), 8);
        if (got_c.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("rr_chan", got_c[i], rr_c[i]);
                chk("rr_data", int'(got_d[i]), int'(rr_d[i]));
            end
        end

        // Hold under backpressure.
        bload = 1'b0;
        asend = 4'b1000; set_ch(3, 8'hA1);
        step();
        set_ch(3, 8'hA2);
        step();
        asend = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_v", int'(bvalid), 1);
            chk("hold_d", int'(bdata), 'hA1);
            chk("hold_c", int'(bchan), 3);
        end
        bload = 1'b1;
        step();
        chk("hold_next", int'(bdata), 'hA2);
        bload = 1'b0;
        step();

        // Mid-stream reset discards buffered words.
        for (int k = 1; k <= 3; k++) begin
            asend = 4'b0010; set_ch(1, DW'(8'hB0 + k));
            step();
        end
        asend = '0;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("mrst_v", int'(bvalid), 0);
        chk("mrst_rdy", int'(aready), 'hF);
        got_d.delete(); got_c.delete();
        asend = 4'b0001; set_ch(0, 8'hA5); bload = 1'b1;
        step();
        asend = '0;
        for (int i = 0; i < 6; i++) begin step(); record(); end
        chk("mrst_n", got_d.size(), 1);
        if (got_d.size() == 1) begin
            chk("mrst_d", int'(got_d[0]), 'hA5);
            chk("mrst_c", got_c[0], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
